// File: rtl/clkgen_multi_pkg.sv
// Shared constants and types for the multi-channel clock generator.
package clkgen_multi_pkg;

    // A divider value of zero turns a channel off.
    localparam int CH_DISABLE = 0;

    // Width of the saturating count of completed output periods.
    localparam int LOCK_CNT_W = 4;

    // Divider-change tracking per channel.
    typedef enum logic {
        CHG_IDLE = 1'b0,
        CHG_WAIT = 1'b1
    } chg_state_t;

    // Increment that stops at all-ones.
    function automatic logic [LOCK_CNT_W-1:0] lock_inc(input logic [LOCK_CNT_W-1:0] v);
        return (v == {LOCK_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/clkgen_channel.sv
// One output channel: active/pending divider, period counter, registered
// clk_out/ce and lock tracking.
//
// state    | meaning
// ---------+------------------------------------------------------------
// CHG_IDLE | active divider is current; ce pulses count towards lock
// CHG_WAIT | a new divider is pending until the current period wraps
module clkgen_channel
    import clkgen_multi_pkg::*;
#(
    parameter int DIV_WIDTH    = 16,
    parameter int DEFAULT_DIV  = 5,
    parameter int LOCK_PERIODS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [DIV_WIDTH-1:0] wr_div,
    output logic                 clk_out,
    output logic                 ce,
    output logic                 locked
);

    localparam logic [DIV_WIDTH-1:0]  DIV_OFF  = DIV_WIDTH'(CH_DISABLE);
    localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0]  DIV_RST  = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [LOCK_CNT_W-1:0] LOCK_TGT = LOCK_CNT_W'(LOCK_PERIODS);

    logic [DIV_WIDTH-1:0]  act_div, act_nxt;
    logic [DIV_WIDTH-1:0]  pend_div, pend_nxt;
    logic [DIV_WIDTH-1:0]  cnt, cnt_nxt;
    logic [DIV_WIDTH-1:0]  new_div;
    logic [LOCK_CNT_W-1:0] per_cnt, per_nxt;
    chg_state_t            chg_state, chg_nxt;
    logic                  at_wrap, wr_fast, change, adopt;
    logic                  clk_nxt, ce_nxt, locked_nxt;

    // Next-state: divider changeover, counter, and the output values that
    // the registers will present in the coming cycle.
    always_comb begin
        at_wrap  = (act_div > DIV_ONE) && (cnt == act_div - DIV_ONE);
        // Disable and divide-by-one take effect at once: there is no
        // period boundary worth waiting for.
        wr_fast  = wr_en && (wr_div <= DIV_ONE);
        // A write landing on the wrap cycle is adopted at that wrap.
        new_div  = wr_en ? wr_div : pend_div;
        change   = wr_en || (chg_state == CHG_WAIT);
        adopt    = change && (at_wrap || (act_div <= DIV_ONE) || wr_fast);

        pend_nxt = new_div;
        act_nxt  = adopt ? new_div : act_div;
        chg_nxt  = (change && !adopt) ? CHG_WAIT : CHG_IDLE;

        if ((act_nxt <= DIV_ONE) || adopt || at_wrap) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + DIV_ONE;
        end

        clk_nxt = 1'b0;
        ce_nxt  = 1'b0;
        if (act_nxt == DIV_ONE) begin
            clk_nxt = 1'b1;
            ce_nxt  = 1'b1;
        end else if (act_nxt != DIV_OFF) begin
            // Odd dividers give the shorter phase to the high level.
            clk_nxt = (cnt_nxt < (act_nxt >> 1));
            ce_nxt  = (cnt_nxt == act_nxt - DIV_ONE);
        end

        // Only periods of the adopted divider count towards lock.
        if (wr_en) begin
            per_nxt = '0;
        end else if (ce_nxt && (chg_nxt == CHG_IDLE)) begin
            per_nxt = lock_inc(per_cnt);
        end else begin
            per_nxt = per_cnt;
        end

        locked_nxt = (act_nxt != DIV_OFF) && (per_nxt >= LOCK_TGT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_div   <= DIV_RST;
            pend_div  <= DIV_RST;
            cnt       <= '0;
            per_cnt   <= '0;
            chg_state <= CHG_IDLE;
            clk_out   <= 1'b0;
            ce        <= 1'b0;
            locked    <= 1'b0;
        end else begin
            act_div   <= act_nxt;
            pend_div  <= pend_nxt;
            cnt       <= cnt_nxt;
            per_cnt   <= per_nxt;
            chg_state <= chg_nxt;
            clk_out   <= clk_nxt;
            ce        <= ce_nxt;
            locked    <= locked_nxt;
        end
    end

endmodule

// File: rtl/clkgen_multi.sv
// Runtime-programmable multi-channel clock generator: NUM_CH divided clocks
// with matching enable pulses and per-channel lock status.
module clkgen_multi
    import clkgen_multi_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DIV_WIDTH    = 16,
    parameter int CH_WIDTH     = 2,
    parameter int DEFAULT_DIV  = 5,
    parameter int LOCK_PERIODS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [CH_WIDTH-1:0]  wr_ch,
    input  logic [DIV_WIDTH-1:0] wr_div,
    output logic [NUM_CH-1:0]    clk_out,
    output logic [NUM_CH-1:0]    ce,
    output logic [NUM_CH-1:0]    locked,
    output logic                 all_locked
);

    logic [NUM_CH-1:0] wr_sel;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Channel select decode; codes at or above NUM_CH match nothing.
        always_comb begin
            wr_sel[i] = wr_en && (wr_ch == CH_WIDTH'(i));
        end

        clkgen_channel #(
            .DIV_WIDTH    (DIV_WIDTH),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .LOCK_PERIODS (LOCK_PERIODS)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_en   (wr_sel[i]),
            .wr_div  (wr_div),
            .clk_out (clk_out[i]),
            .ce      (ce[i]),
            .locked  (locked[i])
        );
    end

    // Summary lock flag, one cycle behind the per-channel flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            all_locked <= 1'b0;
        end else begin
            all_locked <= &locked;
        end
    end

endmodule

// File: tb/tb_clkgen_multi.sv
// Bench for clkgen_multi: a 4-channel instance (A) and a 3-channel
// instance (B) share clock and reset; a timeline model predicts every
// output each cycle, and a few literal checks pin the model.
module tb_clkgen_multi;

    localparam int DW     = 16;
    localparam int LOCK_N = 2;
    localparam int NM     = 7;   // model channels: 0..3 -> A, 4..6 -> B

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b1;
    logic          wr_en_a  = 1'b0;
    logic [1:0]    wr_ch_a  = '0;
    logic [DW-1:0] wr_div_a = '0;
    logic          wr_en_b  = 1'b0;
    logic [1:0]    wr_ch_b  = '0;
    logic [DW-1:0] wr_div_b = '0;

    logic [3:0] clk_out_a, ce_a, locked_a;
    logic       all_locked_a;
    logic [2:0] clk_out_b, ce_b, locked_b;
    logic       all_locked_b;

    clkgen_multi dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en_a),
        .wr_ch      (wr_ch_a),
        .wr_div     (wr_div_a),
        .clk_out    (clk_out_a),
        .ce         (ce_a),
        .locked     (locked_a),
        .all_locked (all_locked_a)
    );

    clkgen_multi #(.NUM_CH(3)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en_b),
        .wr_ch      (wr_ch_b),
        .wr_div     (wr_div_b),
        .clk_out    (clk_out_b),
        .ce         (ce_b),
        .locked     (locked_b),
        .all_locked (all_locked_b)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Timeline model: cycle t counts rising edges since reset release.
    // A channel's waveform is fixed by its divider and the cycle at which
    // that divider's period 0 began.
    int t;
    int m_d[NM], m_start[NM], m_nxt[NM], m_lcnt[NM], m_lastwr[NM];
    bit m_has[NM];
    bit ex_clk[NM], ex_ce[NM], ex_lock[NM];
    bit ex_all_a, ex_all_b;

    function automatic int m_phase(int c, int tt);
        if (m_d[c] < 2) return 0;
        return (tt - m_start[c]) % m_d[c];
    endfunction

    task automatic model_reset();
        t = 0;
        for (int c = 0; c < NM; c++) begin
            m_d[c] = 5;  m_start[c] = 0;  m_nxt[c] = 0;  m_has[c] = 1'b0;
            m_lcnt[c] = 0;  m_lastwr[c] = 0;
            ex_clk[c] = 1'b0;  ex_ce[c] = 1'b0;  ex_lock[c] = 1'b0;
        end
        ex_all_a = 1'b0;
        ex_all_b = 1'b0;
    endtask

    task automatic model_step();
        bit all_a, all_b, hit;
        int nd, ph;
        all_a = 1'b1;
        all_b = 1'b1;
        for (int c = 0; c < 4; c++)  all_a &= ex_lock[c];
        for (int c = 4; c < NM; c++) all_b &= ex_lock[c];
        t = t + 1;
        for (int c = 0; c < NM; c++) begin
            hit = 1'b0;
            nd  = 0;
            if (c < 4 && wr_en_a && int'(wr_ch_a) == c) begin
                hit = 1'b1;  nd = int'(wr_div_a);
            end
            if (c >= 4 && wr_en_b && int'(wr_ch_b) < 3 && int'(wr_ch_b) + 4 == c) begin
                hit = 1'b1;  nd = int'(wr_div_b);
            end
            if (hit) begin
                m_lastwr[c] = t;
                m_lcnt[c]   = 0;
                if (nd <= 1 || m_d[c] <= 1 || m_phase(c, t) == 0) begin
                    m_d[c] = nd;  m_start[c] = t;  m_has[c] = 1'b0;
                end else begin
                    m_nxt[c] = nd;  m_has[c] = 1'b1;
                end
            end else if (m_has[c] && m_phase(c, t) == 0) begin
                m_d[c] = m_nxt[c];  m_start[c] = t;  m_has[c] = 1'b0;
            end
            if (m_d[c] == 0) begin
                ex_clk[c] = 1'b0;  ex_ce[c] = 1'b0;
            end else if (m_d[c] == 1) begin
                ex_clk[c] = 1'b1;  ex_ce[c] = 1'b1;
            end else begin
                ph = m_phase(c, t);
                ex_clk[c] = (ph < m_d[c] / 2);
                ex_ce[c]  = (ph == m_d[c] - 1);
            end
            if (ex_ce[c] && t > m_lastwr[c] && !m_has[c] && m_lcnt[c] < 15)
                m_lcnt[c]++;
            ex_lock[c] = (m_d[c] != 0) && (m_lcnt[c] >= LOCK_N);
        end
        ex_all_a = all_a;
        ex_all_b = all_b;
    endtask

    // Model advances on the same edges as the DUTs.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    function automatic logic [3:0] exp_a(int kind);
        logic [3:0] r;
        for (int c = 0; c < 4; c++)
            r[c] = (kind == 0) ? ex_clk[c] : (kind == 1) ? ex_ce[c] : ex_lock[c];
        return r;
    endfunction

    function automatic logic [2:0] exp_b(int kind);
        logic [2:0] r;
        for (int c = 0; c < 3; c++)
            r[c] = (kind == 0) ? ex_clk[c+4] : (kind == 1) ? ex_ce[c+4] : ex_lock[c+4];
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, t, got, want);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        check("clk_out_a",    8'(clk_out_a),    8'(exp_a(0)));
        check("ce_a",         8'(ce_a),         8'(exp_a(1)));
        check("locked_a",     8'(locked_a),     8'(exp_a(2)));
        check("all_locked_a", 8'(all_locked_a), 8'(ex_all_a));
        check("clk_out_b",    8'(clk_out_b),    8'(exp_b(0)));
        check("ce_b",         8'(ce_b),         8'(exp_b(1)));
        check("locked_b",     8'(locked_b),     8'(exp_b(2)));
        check("all_locked_b", 8'(all_locked_b), 8'(ex_all_b));
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_a(input int ch, input int div);
        wr_en_a  = 1'b1;
        wr_ch_a  = 2'(ch);
        wr_div_a = DW'(div);
        @(negedge clk);
        wr_en_a  = 1'b0;
    endtask

    task automatic wait_phase(input int c, input int ph);
        int k = 0;
        while (m_phase(c, t) != ph && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_phase ch%0d: phase %0d not reached", c, ph);
        end
    endtask

    task automatic wait_ce(input int c);
        int k = 0;
        while (!ex_ce[c] && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_ce ch%0d: no ce pulse", c);
        end
    endtask

    // Hand-derived expectations for the first periods after reset release.
    task automatic startup_pins(input string tag);
        run(1);  check({tag, "_t1_clk"},   8'(clk_out_a), 8'h0F);
        run(1);  check({tag, "_t2_clk"},   8'(clk_out_a), 8'h00);
        run(2);  check({tag, "_t4_ce"},    8'(ce_a),      8'h0F);
                 check({tag, "_t4_lock"},  8'(locked_a),  8'h00);
        run(1);  check({tag, "_t5_clk"},   8'(clk_out_a), 8'h0F);
        run(3);  check({tag, "_t8_lock"},  8'(locked_a),  8'h00);
        run(1);  check({tag, "_t9_lock"},  8'(locked_a),  8'h0F);
                 check({tag, "_t9_all"},   8'(all_locked_a), 8'h00);
                 check({tag, "_t9_lockb"}, 8'(locked_b),  8'h07);
        run(1);  check({tag, "_t10_all"},  8'(all_locked_a), 8'h01);
                 check({tag, "_t10_allb"}, 8'(all_locked_b), 8'h01);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        run(3);
        reset_n = 1'b1;
        startup_pins("rst1");

        // ch1 -> 8, written while cnt == 2: current 5-period completes first.
        wait_phase(1, 2);
        write_a(1, 8);
        check("ch1_lock_drop", 8'(locked_a[1]), 8'h00);
        run(5);  check("ch1_d8_high",   8'(clk_out_a[1]), 8'h01);
        run(11); check("ch1_lock_wait", 8'(locked_a[1]),  8'h00);
        run(1);  check("ch1_lock_back", 8'(locked_a[1]),  8'h01);
        run(20);

        // ch2 disable, then re-enable at 3.
        write_a(2, 0);
        check("ch2_off_clk",  8'(clk_out_a[2]), 8'h00);
        check("ch2_off_ce",   8'(ce_a[2]),      8'h00);
        check("ch2_off_lock", 8'(locked_a[2]),  8'h00);
        run(5);
        write_a(2, 3);
        check("ch2_on_clk",   8'(clk_out_a[2]), 8'h01);
        run(2);  check("ch2_on_ce",     8'(ce_a[2]),     8'h01);
        run(2);  check("ch2_lock_wait", 8'(locked_a[2]), 8'h00);
        run(1);  check("ch2_lock_back", 8'(locked_a[2]), 8'h01);
        run(10);

        // ch0 -> 6 exactly on a wrap, then 7 before the next wrap.
        wait_ce(0);
        write_a(0, 6);
        check("ch0_d6_clk",  8'(clk_out_a[0]), 8'h01);
        check("ch0_d6_lock", 8'(locked_a[0]),  8'h00);
        run(1);
        write_a(0, 7);
        run(3);  check("ch0_d6_ce",     8'(ce_a[0]),     8'h01);
        run(13); check("ch0_lock_wait", 8'(locked_a[0]), 8'h00);
        run(1);  check("ch0_lock_back", 8'(locked_a[0]), 8'h01);
        run(15);

        // ch3 -> 1 on A; on B (3 channels) the same channel code is ignored.
        wr_en_a = 1'b1;  wr_ch_a = 2'd3;  wr_div_a = 16'd1;
        wr_en_b = 1'b1;  wr_ch_b = 2'd3;  wr_div_b = 16'd1;
        @(negedge clk);
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        check("ch3_d1_ce",   8'(ce_a[3]),      8'h01);
        check("ch3_d1_clk",  8'(clk_out_a[3]), 8'h01);
        check("ch3_d1_lock", 8'(locked_a[3]),  8'h00);
        run(1);  check("ch3_lock_wait", 8'(locked_a[3]), 8'h00);
                 check("b_undisturbed", 8'(locked_b),    8'h07);
        run(1);  check("ch3_lock_back", 8'(locked_a[3]), 8'h01);
        run(12);

        // Reset mid-period with a divider change still pending on ch1.
        wait_phase(1, 2);
        write_a(1, 12);
        run(1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_clk_out", 8'(clk_out_a),    8'h00);
        check("rst_ce",      8'(ce_a),         8'h00);
        check("rst_locked",  8'(locked_a),     8'h00);
        check("rst_all",     8'(all_locked_a), 8'h00);
        run(2);
        reset_n = 1'b1;
        startup_pins("rst2");
        run(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
